// File: rtl/memory_game_ctrl_param_if.sv
// Bus between the memory-game controller and its buttons, LFSRs, LCD writer and LEDs.
// The controller takes the master modport; the surrounding glue takes the slave modport.
interface memory_game_ctrl_param_if #(
  parameter int DATA_W  = 8,
  parameter int SCORE_W = 8,
  parameter int LEN_W   = 5
);
  logic              start_pulse;
  logic              next_pulse;
  logic              enter_pulse;
  logic [DATA_W-1:0] rand_sym;
  logic [2:0]        rand_slot;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_done;
  logic              red_led;
  logic              green_led;
  logic              flag_led;
  logic              win_led;
  logic [SCORE_W-1:0] score;
  logic              score_inc;
  logic [LEN_W-1:0]  round_len;

  modport master (
    input  start_pulse, next_pulse, enter_pulse, rand_sym, rand_slot, disp_done,
    output disp_data, disp_valid, red_led, green_led, flag_led, win_led,
           score, score_inc, round_len
  );

  modport slave (
    output start_pulse, next_pulse, enter_pulse, rand_sym, rand_slot, disp_done,
    input  disp_data, disp_valid, red_led, green_led, flag_led, win_led,
           score, score_inc, round_len
  );
endinterface

// File: rtl/memory_game_ctrl_param.sv
// Memory-recall game controller: grows a random symbol history and has the player recall it newest first.
// Define MEMORY_GAME_TIMEOUT_EN to auto-advance the candidate after TIMEOUT_CYC idle cycles in A_WAIT.
module memory_game_ctrl_param #(
  parameter int DATA_W      = 8,
  parameter int MAX_LEN     = 16,
  parameter int CHOICES     = 4,
  parameter int SCORE_W     = 8,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic clk,
  input  logic rst,
  memory_game_ctrl_param_if.master bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int POS_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] Q_LOAD   = 4'd1;
  localparam logic [3:0] Q_SHOW   = 4'd2;
  localparam logic [3:0] Q_WAIT   = 4'd3;
  localparam logic [3:0] A_SETUP  = 4'd4;
  localparam logic [3:0] A_SHOW   = 4'd5;
  localparam logic [3:0] A_WAIT   = 4'd6;
  localparam logic [3:0] ROUND_OK = 4'd7;
  localparam logic [3:0] OVER     = 4'd8;
  localparam logic [3:0] WIN      = 4'd9;

  logic [3:0]         state;
  logic [DATA_W-1:0]  hist [MAX_LEN];
  logic [LEN_W-1:0]   roundLen;
  logic [POS_W-1:0]   pos;
  logic [2:0]         cand;
  logic [2:0]         slot;
  logic [DATA_W-1:0]  correct;
  logic [DATA_W-1:0]  shown;
  logic [SCORE_W-1:0] score;
  logic               redLed, greenLed, flagLed, winLed;

  logic [DATA_W-1:0]  setupCorrect, setupShown, stepShown;
  logic [2:0]         setupSlot, candNext;
  logic               nextAct, enterAct, toHit;

  // A distractor is never allowed to equal the correct symbol.
  function automatic logic [DATA_W-1:0] distract(input logic [DATA_W-1:0] sym,
                                                 input logic [DATA_W-1:0] corr);
    return (sym == corr) ? (sym ^ DATA_W'(1)) : sym;
  endfunction

  always_comb begin
    setupCorrect = hist[pos];
    setupSlot    = 3'(bus.rand_slot % CHOICES);
    setupShown   = (setupSlot == 3'd0) ? setupCorrect : distract(bus.rand_sym, setupCorrect);
    candNext     = cand + 3'd1;
    stepShown    = (candNext == slot) ? correct : distract(bus.rand_sym, correct);
    enterAct     = bus.enter_pulse & ~bus.next_pulse;
    nextAct      = (bus.next_pulse | toHit) & ~bus.enter_pulse;
  end

`ifdef MEMORY_GAME_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] toCnt;

  // Held at reload outside A_WAIT so it starts fresh on every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      toCnt <= '0;
    end else if (state != A_WAIT || bus.next_pulse || bus.enter_pulse) begin
      toCnt <= TO_W'(TIMEOUT_CYC - 1);
    end else if (toCnt != '0) begin
      toCnt <= toCnt - 1'b1;
    end
  end

  assign toHit = (state == A_WAIT) && (toCnt == '0);
`else
  assign toHit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) hist[i] <= '0;
    end else if (state == Q_LOAD) begin
      for (int i = 0; i < MAX_LEN; i++)
        if (roundLen == LEN_W'(i)) hist[i] <= bus.rand_sym;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      roundLen <= '0;
      pos      <= '0;
      cand     <= '0;
      slot     <= '0;
      correct  <= '0;
      shown    <= '0;
      score    <= '0;
      redLed   <= 1'b0;
      greenLed <= 1'b0;
      flagLed  <= 1'b0;
      winLed   <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER, WIN: begin
          if (bus.start_pulse) begin
            score    <= '0;
            roundLen <= '0;
            flagLed  <= 1'b0;
            winLed   <= 1'b0;
            state    <= Q_LOAD;
          end
        end
        Q_LOAD: begin
          roundLen <= roundLen + 1'b1;
          shown    <= bus.rand_sym;
          redLed   <= 1'b1;
          greenLed <= 1'b0;
          state    <= Q_SHOW;
        end
        Q_SHOW: if (bus.disp_done) state <= Q_WAIT;
        Q_WAIT: begin
          if (bus.next_pulse) begin
            pos      <= POS_W'(roundLen - 1'b1);
            redLed   <= 1'b0;
            greenLed <= 1'b1;
            state    <= A_SETUP;
          end
        end
        A_SETUP: begin
          correct <= setupCorrect;
          slot    <= setupSlot;
          cand    <= 3'd0;
          shown   <= setupShown;
          state   <= A_SHOW;
        end
        A_SHOW: if (bus.disp_done) state <= A_WAIT;
        A_WAIT: begin
          if (enterAct) begin
            if (shown != correct) begin
              flagLed  <= 1'b1;
              redLed   <= 1'b0;
              greenLed <= 1'b0;
              state    <= OVER;
            end else if (pos == '0) begin
              state <= ROUND_OK;
            end else begin
              pos   <= pos - 1'b1;
              state <= A_SETUP;
            end
          end else if (nextAct) begin
            // Stepping past the last candidate means the correct one was skipped.
            if (cand == 3'(CHOICES - 1)) begin
              flagLed  <= 1'b1;
              redLed   <= 1'b0;
              greenLed <= 1'b0;
              state    <= OVER;
            end else begin
              cand  <= candNext;
              shown <= stepShown;
              state <= A_SHOW;
            end
          end
        end
        ROUND_OK: begin
          if (score != {SCORE_W{1'b1}}) score <= score + 1'b1;
          if (roundLen == LEN_W'(MAX_LEN)) begin
            winLed   <= 1'b1;
            redLed   <= 1'b0;
            greenLed <= 1'b0;
            state    <= WIN;
          end else begin
            state <= Q_LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_data  = shown;
  assign bus.disp_valid = (state == Q_SHOW) || (state == A_SHOW);
  assign bus.red_led    = redLed;
  assign bus.green_led  = greenLed;
  assign bus.flag_led   = flagLed;
  assign bus.win_led    = winLed;
  assign bus.score      = score;
  assign bus.score_inc  = (state == ROUND_OK);
  assign bus.round_len  = roundLen;
endmodule

// File: doc/memory_game_ctrl_param.md
Name: memory_game_ctrl_param

Overview:
- Parametrised memory-recall game controller, the next generation of the single-sequence LCD game FSM.
- Each round appends one random symbol to an internal history and displays it as the question. The player then recalls the whole history, newest first, by picking the correct symbol among CHOICES candidates.
- Sits between the LFSR sources, button-pulse logic and the LCD writer. Uses an internal register history instead of an external RAM.

Parameters:
- DATA_W, 8, symbol/LCD character width
- MAX_LEN, 16, maximum history length; completing round MAX_LEN wins the game
- CHOICES, 4, candidates shown per recalled position (2..8)
- SCORE_W, 8, score counter width
- TIMEOUT_CYC, 50000000, cycles per candidate before auto-advance (used only with TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- start_pulse  in  1  one-cycle game-start pulse (debounced)
- next_pulse  in  1  one-cycle "next candidate/continue" pulse
- enter_pulse  in  1  one-cycle "select" pulse
- rand_sym  in  DATA_W  free-running LFSR symbol
- rand_slot  in  3  free-running LFSR value; slot = rand_slot mod CHOICES
- disp_data  out  DATA_W  character to LCD writer
- disp_valid  out  1  display request
- disp_done  in  1  LCD writer finished current character
- red_led  out  1  question phase
- green_led  out  1  answer phase
- flag_led  out  1  game over (lost)
- win_led  out  1  game won
- score  out  SCORE_W  completed rounds, saturating
- score_inc  out  1  one-cycle pulse per completed round
- round_len  out  clog2(MAX_LEN+1)  current history length

Behaviour:
- Reset (rst==0 at posedge): state IDLE. All outputs 0; history, round_len, score, position and candidate counters cleared.
- States: IDLE, Q_LOAD, Q_SHOW, Q_WAIT, A_SETUP, A_SHOW, A_WAIT, ROUND_OK, OVER, WIN.
- IDLE/OVER/WIN: start_pulse clears score, round_len and flags, then goes to Q_LOAD. Other inputs are ignored.
- Q_LOAD: history[round_len] <= rand_sym; round_len++; red_led=1, green_led=0; go to Q_SHOW.
- Q_SHOW: disp_data=newest symbol, disp_valid=1. Both are held stable until the cycle disp_done=1 is sampled; disp_valid drops the next cycle; go to Q_WAIT.
- Q_WAIT: next_pulse sets pos=round_len-1, red_led=0, green_led=1, then A_SETUP.
- A_SETUP (1 cycle):
  - correct = history[pos]; latch slot = rand_slot mod CHOICES; cand=0.
- A_SHOW candidate display:
  - cand==slot: show correct.
  - Otherwise: show rand_sym sampled at entry. If equal to correct, show rand_sym ^ 1 instead (a distractor never equals correct).
  - The shown value is stored; same display handshake as Q_SHOW; go to A_WAIT.
- A_WAIT:
  - enter_pulse alone, shown==correct: if pos==0, go to ROUND_OK; else pos--, then A_SETUP.
  - enter_pulse alone, shown!=correct: go to OVER, flag_led=1.
  - next_pulse alone, cand<CHOICES-1: cand++, then A_SHOW.
  - next_pulse alone, cand==CHOICES-1: go to OVER (correct symbol was skipped).
  - next_pulse and enter_pulse in the same cycle: both ignored, stay.
- ROUND_OK: score++ (saturates at all-ones); score_inc=1 for exactly one cycle. If round_len==MAX_LEN, go to WIN with win_led=1; else go to Q_LOAD.
- LEDs: red/green cleared on entering OVER/WIN. flag_led and win_led hold until start_pulse or reset.
- Buttons pressed during display states are ignored; no queuing.
- Reset mid-display: disp_valid drops the same cycle; a late disp_done is ignored in IDLE.
- Latency from a correct enter to the next candidate's disp_valid: 2 cycles (A_SETUP, A_SHOW).

Optional Feature:
- Macro MEMORY_GAME_TIMEOUT_EN.
- Defined:
  - A per-candidate counter loads TIMEOUT_CYC-1 on entering A_WAIT and decrements each cycle.
  - At zero, it acts exactly as next_pulse (including OVER on the last candidate).
  - Any button event reloads it.
- Undefined: no counter is instantiated, TIMEOUT_CYC is unused, and A_WAIT waits indefinitely.

Test Plan:
- Reset, then start_pulse with rand_sym=0x41: Q_SHOW presents 0x41 with red_led=1. disp_done, then next_pulse gives green_led=1 and the first candidate displayed; enter on the correct slot gives score=1, score_inc one cycle, round_len=1.
- Round 2 with history {0x41,0x42}: correct picks 0x42 then 0x41 give score=2. Picking 0x41 first (wrong) gives OVER, flag_led=1, green_led=0.
- CHOICES=4, slot=3: three next_pulses reach the correct candidate and enter succeeds. With slot=2, four next_pulses give OVER.
- Distractor collision: rand_sym equal to the correct 0x41 on a non-correct slot gives disp_data=0x40; simultaneous next+enter leaves the state unchanged.
- MAX_LEN=2, all answers correct: win_led=1 after round 2 and score=2; start_pulse clears score and round_len and re-enters Q_LOAD.
- With MEMORY_GAME_TIMEOUT_EN, TIMEOUT_CYC=10: no press advances the candidate after 10 cycles. Reset asserted mid-A_SHOW gives all outputs 0 on the next cycle.
